usb_host_rx_router: RTL and testbench

//  Receive-side counterpart of the host TX PHY arbiter. Takes the single PHY RX byte stream and

---
 rtl/usb_host_rx_router.sv | 194 +++++++++++++++++++
 tb/tb_usb_host_rx_router.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_rx_router.sv
// Routes PHY RX response packets to the host client owning the last TX.
// Flags bad PIDs, PHY errors and over-length packets; drops unsolicited RX.
module usb_host_rx_router #(
  parameter int TIMEOUT_CYCLES = 96,
  parameter int MAX_PKT_BYTES  = 1027,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_done,
  input  logic [3:0]       tx_owner,
  input  logic             bus_reset,
  input  logic             phy_rx_active,
  input  logic             phy_rx_valid,
  input  logic [7:0]       phy_rx_data,
  input  logic             phy_rx_error,
  output logic [3:0]       rx_dest,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_sop,
  output logic             rx_eop,
  output logic             rx_err,
  output logic [3:0]       rx_pid,
  output logic [3:0]       rx_timeout,
  output logic [CNT_W-1:0] unsolicited_cnt,
  output logic             busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RESP = 2'd1;
  localparam logic [1:0] RX_PKT    = 2'd2;
  localparam logic [1:0] DROP      = 2'd3;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [10:0] MAX_B = 11'(MAX_PKT_BYTES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       owner_q, owner_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [10:0]      bcnt_q, bcnt_d;
  logic             err_q, err_d;
  logic             act_q;

  logic [3:0]       dest_d;
  logic             valid_d;
  logic [7:0]       data_d;
  logic             sop_d;
  logic             eop_d;
  logic             errout_d;
  logic [3:0]       pid_d;
  logic [3:0]       tmo_d;
  logic [CNT_W-1:0] ucnt_d;

  logic [3:0] owner_sel;
  logic       owner_req;
  logic       rx_start;
  logic       byte_in;
  logic       pid_bad;
  logic       over_len;

  // Isolate the lowest set bit so the lowest-index owner wins.
  assign owner_sel = tx_owner & (~tx_owner + 4'd1);
  assign owner_req = tx_done & (|tx_owner);
  assign rx_start  = phy_rx_active & ~act_q;
  assign byte_in   = phy_rx_active & phy_rx_valid;
  assign pid_bad   = phy_rx_data[7:4] != ~phy_rx_data[3:0];
  assign over_len  = bcnt_q >= MAX_B;
  assign busy      = state_q != IDLE;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    bcnt_d   = bcnt_q;
    err_d    = err_q;
    dest_d   = 4'd0;
    valid_d  = 1'b0;
    data_d   = rx_data;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    errout_d = 1'b0;
    pid_d    = rx_pid;
    tmo_d    = 4'd0;
    ucnt_d   = unsolicited_cnt;

    if (bus_reset) begin
      if (state_q == RX_PKT) begin
        eop_d    = 1'b1;
        errout_d = 1'b1;
        dest_d   = owner_q;
      end
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (owner_req) begin
            state_d = WAIT_RESP;
            owner_d = owner_sel;
            timer_d = TMR_LOAD;
          end else if (rx_start) begin
            state_d = DROP;
            if (unsolicited_cnt != {CNT_W{1'b1}})
              ucnt_d = unsolicited_cnt + CNT_W'(1);
          end
        end
        WAIT_RESP: begin
          // A first byte on the expiry cycle still wins.
          if (byte_in) begin
            state_d = RX_PKT;
            valid_d = 1'b1;
            sop_d   = 1'b1;
            data_d  = phy_rx_data;
            dest_d  = owner_q;
            pid_d   = phy_rx_data[3:0];
            bcnt_d  = 11'd1;
            err_d   = pid_bad | phy_rx_error;
          end else if (owner_req) begin
            owner_d = owner_sel;
            timer_d = TMR_LOAD;
          end else if (timer_q <= TMR_W'(1)) begin
            tmo_d   = owner_q;
            state_d = IDLE;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        RX_PKT: begin
          if (!phy_rx_active) begin
            eop_d    = 1'b1;
            errout_d = err_q;
            dest_d   = owner_q;
            state_d  = IDLE;
            err_d    = 1'b0;
          end else begin
            err_d = err_q | phy_rx_error | (byte_in & over_len);
            if (byte_in) begin
              if (!over_len) begin
                valid_d = 1'b1;
                data_d  = phy_rx_data;
                dest_d  = owner_q;
              end
              if (bcnt_q != 11'h7ff)
                bcnt_d = bcnt_q + 11'd1;
            end
          end
        end
        DROP: begin
          if (!phy_rx_active)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_q         <= 4'd0;
      timer_q         <= '0;
      bcnt_q          <= 11'd0;
      err_q           <= 1'b0;
      act_q           <= 1'b0;
      rx_dest         <= 4'd0;
      rx_valid        <= 1'b0;
      rx_data         <= 8'd0;
      rx_sop          <= 1'b0;
      rx_eop          <= 1'b0;
      rx_err          <= 1'b0;
      rx_pid          <= 4'd0;
      rx_timeout      <= 4'd0;
      unsolicited_cnt <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      timer_q         <= timer_d;
      bcnt_q          <= bcnt_d;
      err_q           <= err_d;
      act_q           <= phy_rx_active;
      rx_dest         <= dest_d;
      rx_valid        <= valid_d;
      rx_data         <= data_d;
      rx_sop          <= sop_d;
      rx_eop          <= eop_d;
      rx_err          <= errout_d;
      rx_pid          <= pid_d;
      rx_timeout      <= tmo_d;
      unsolicited_cnt <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_usb_host_rx_router.sv
// Scoreboard bench for usb_host_rx_router: packet-level model queues
// expected bytes/eops/timeouts, a negedge monitor pops and compares.
module tb_usb_host_rx_router;

  localparam int TMO  = 96;
  localparam int MAXB = 1027;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_done = 1'b0;
  logic [3:0]    tx_owner = 4'd0;
  logic          bus_reset = 1'b0;
  logic          phy_rx_active = 1'b0;
  logic          phy_rx_valid = 1'b0;
  logic [7:0]    phy_rx_data = 8'd0;
  logic          phy_rx_error = 1'b0;
  logic [3:0]    rx_dest;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_sop;
  logic          rx_eop;
  logic          rx_err;
  logic [3:0]    rx_pid;
  logic [3:0]    rx_timeout;
  logic [CW-1:0] unsolicited_cnt;
  logic          busy;

  usb_host_rx_router #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_PKT_BYTES(MAXB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_done(tx_done),
    .tx_owner(tx_owner),
    .bus_reset(bus_reset),
    .phy_rx_active(phy_rx_active),
    .phy_rx_valid(phy_rx_valid),
    .phy_rx_data(phy_rx_data),
    .phy_rx_error(phy_rx_error),
    .rx_dest(rx_dest),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_sop(rx_sop),
    .rx_eop(rx_eop),
    .rx_err(rx_err),
    .rx_pid(rx_pid),
    .rx_timeout(rx_timeout),
    .unsolicited_cnt(unsolicited_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;
    logic [3:0] dest;
    logic [7:0] data;
    logic       sop;
    logic       err;
    logic [3:0] pid;
  } ev_t;

  typedef logic [7:0] bq_t[$];

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_EOP  = 2'd1;
  localparam logic [1:0] K_TMO  = 2'd2;

  ev_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int ucnt_model = 0;
  logic [31:0] cyc = 0;
  logic [31:0] tdone_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) tdone_cyc <= cyc + 1;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] low1(logic [3:0] o);
    for (int i = 0; i < 4; i++)
      if (o[i]) return 4'(1 << i);
    return 4'd0;
  endfunction

  function automatic bq_t make_pkt(int n, bit good);
    bq_t b;
    logic [3:0] p;
    p = 4'($urandom);
    b.push_back(good ? {~p, p} : {p, p});
    for (int i = 1; i < n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  // Monitor: every output event must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (rx_valid) begin
        chk("byte_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("byte", {rx_eop, K_BYTE, rx_dest, rx_data, rx_sop},
              {1'b0, e.kind, e.dest, e.data, e.sop});
          if (rx_sop) chk("pid_at_sop", 64'(rx_pid), 64'(e.pid));
        end
      end
      if (rx_eop) begin
        chk("eop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("eop", {K_EOP, rx_dest, rx_err, rx_pid},
              {e.kind, e.dest, e.err, e.pid});
        end
      end
      if (rx_timeout != 4'd0) begin
        chk("tmo_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("timeout", {K_TMO, rx_timeout, cyc - tdone_cyc},
              {e.kind, e.dest, 32'(TMO)});
        end
      end
    end
  end

  task automatic drv(logic act, logic vld, logic [7:0] d, logic er, logic br);
    @(negedge clk);
    tx_done = 1'b0;
    tx_owner = 4'd0;
    phy_rx_active = act;
    phy_rx_valid = vld;
    phy_rx_data = d;
    phy_rx_error = er;
    bus_reset = br;
  endtask

  task automatic idle(int n);
    repeat (n) drv(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic issue_tx(logic [3:0] o);
    @(negedge clk);
    tx_done = 1'b1;
    tx_owner = o;
    phy_rx_active = 1'b0;
    phy_rx_valid = 1'b0;
    phy_rx_error = 1'b0;
    bus_reset = 1'b0;
  endtask

  task automatic send_pkt(bq_t b, int err_at, int br_at, bit sol, logic [3:0] dest);
    ev_t e;
    bit aborted = 0;
    logic [3:0] pid = b[0][3:0];
    logic bad = (b[0][7:4] != ~b[0][3:0]) || err_at >= 0 || b.size() > MAXB;
    for (int i = 0; i < b.size(); i++) begin
      logic br = br_at >= 0 && i >= br_at && i < br_at + 3;
      if (i > 0 && $urandom_range(0, 3) == 0)
        drv(1'b1, 1'b0, 8'($urandom), 1'b0, br);
      drv(1'b1, 1'b1, b[i], i == err_at, br);
      if (br_at >= 0 && i == br_at + 1)
        chk("busy_after_bus_reset", 64'(busy), 64'd0);
      if (sol && i == br_at) begin
        aborted = 1;
        e = '{K_EOP, dest, 8'd0, 1'b0, 1'b1, pid};
        exp_q.push_back(e);
      end
      if (sol && !aborted && i < MAXB) begin
        e = '{K_BYTE, dest, b[i], i == 0, 1'b0, pid};
        exp_q.push_back(e);
      end
    end
    drv(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    if (sol && !aborted) begin
      e = '{K_EOP, dest, 8'd0, 1'b0, bad, pid};
      exp_q.push_back(e);
    end
    if (!sol && ucnt_model < (1 << CW) - 1) ucnt_model++;
    idle(3);
    if (!sol) chk("unsolicited_cnt", 64'(unsolicited_cnt), 64'(ucnt_model));
  endtask

  task automatic do_resp(logic [3:0] o, bq_t b, int err_at, int br_at);
    issue_tx(o);
    idle($urandom_range(0, 40));
    send_pkt(b, err_at, br_at, 1, low1(o));
  endtask

  task automatic do_timeout(logic [3:0] o, logic [3:0] o2);
    ev_t e;
    issue_tx(o);
    if (o2 != 4'd0) begin
      idle(30);
      issue_tx(o2);
    end
    e = '{K_TMO, low1(o2 != 4'd0 ? o2 : o), 8'd0, 1'b0, 1'b0, 4'd0};
    exp_q.push_back(e);
    idle(TMO + 14);
    chk("busy_after_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    bq_t b;
    ev_t e;
    int n, err_at, br_at, r;
    logic [3:0] o;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {rx_dest, rx_valid, rx_data, rx_sop, rx_eop, rx_err, rx_pid,
         rx_timeout, unsolicited_cnt, busy}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    b = {8'hD2, 8'h11, 8'h22};
    do_resp(4'b0100, b, -1, -1);
    chk("pid_held_ack", 64'(rx_pid), 64'd2);

    do_timeout(4'b0010, 4'd0);
    do_timeout(4'b0100, 4'b1000);

    for (int k = 0; k < 17; k++) begin
      b = make_pkt(3, 1);
      send_pkt(b, -1, -1, 0, 4'd0);
    end

    b = {8'h33, 8'h01, 8'h02};
    do_resp(4'b1000, b, -1, -1);
    b = make_pkt(6, 1);
    do_resp(4'b1000, b, 3, -1);

    b = make_pkt(1030, 1);
    do_resp(4'b0001, b, -1, -1);

    b = make_pkt(8, 1);
    do_resp(4'b0110, b, -1, 4);

    issue_tx(4'b0010);
    idle(5);
    drv(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    idle(TMO + 10);
    chk("busy_after_wait_reset", 64'(busy), 64'd0);

    b = make_pkt(4, 1);
    issue_tx(4'b0010);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, b[i], 1'b0, 1'b0);
      e = '{K_BYTE, 4'b0010, b[i], i == 0, 1'b0, b[0][3:0]};
      exp_q.push_back(e);
    end
    drv(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    phy_rx_active = 1'b0;
    phy_rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_packet",
        {rx_dest, rx_valid, rx_data, rx_sop, rx_eop, rx_err, rx_pid,
         rx_timeout, unsolicited_cnt, busy}, 64'd0);
    rst_n = 1'b1;
    ucnt_model = 0;
    idle(3);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        o = 4'($urandom_range(1, 15));
        n = $urandom_range(1, 16);
        b = make_pkt(n, $urandom_range(0, 4) != 0);
        err_at = ($urandom_range(0, 5) == 0 && n > 1) ? $urandom_range(1, n - 1) : -1;
        br_at = ($urandom_range(0, 6) == 0 && n >= 4) ? $urandom_range(1, n - 2) : -1;
        if (br_at >= 0) err_at = -1;
        do_resp(o, b, err_at, br_at);
      end else if (r <= 7) begin
        do_timeout(4'($urandom_range(1, 15)),
                   $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'd0);
      end else begin
        b = make_pkt($urandom_range(1, 6), 1);
        send_pkt(b, -1, -1, 0, 4'd0);
      end
    end

    idle(5);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
